// File: rtl/ghost_ai.sv
// ghost_ai: tile-stepping ghost controller for a Pac-Man style maze.
// Each move_tick walks the FSM IDLE -> TARGET -> DECIDE -> STEP and moves
// the ghost one tile toward a personality-dependent target tile.
// Optional feature macro: GHOST_FRIGHT_EN (frightened random walk driven
// by a 16-bit LFSR). Without it, mode 2'b10 behaves like scatter.
module ghost_ai #(
    parameter int GHOST_ID = 2,
    parameter int CW       = 6,
    parameter int MAP_W    = 28,
    parameter int MAP_H    = 36,
    parameter int START_X  = 11,
    parameter int START_Y  = 19,
    parameter int SCAT_X   = 27,
    parameter int SCAT_Y   = 35
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          move_tick,
    input  logic [1:0]    mode,
    input  logic [CW-1:0] pacX,
    input  logic [CW-1:0] pacY,
    input  logic [1:0]    pacDir,
    input  logic [CW-1:0] blinkyX,
    input  logic [CW-1:0] blinkyY,
    input  logic          canMoveUp,
    input  logic          canMoveRight,
    input  logic          canMoveDown,
    input  logic          canMoveLeft,
    output logic [CW-1:0] ghostX,
    output logic [CW-1:0] ghostY,
    output logic [1:0]    dir,
    output logic          step_done,
    output logic          busy
);

    localparam int TW = CW + 3;   // signed target arithmetic width
    localparam int DW = CW + 2;   // unsigned distance width

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] TARGET = 2'd1;
    localparam logic [1:0] DECIDE = 2'd2;
    localparam logic [1:0] STEP   = 2'd3;

    localparam logic [1:0] D_UP    = 2'd0;
    localparam logic [1:0] D_RIGHT = 2'd1;
    localparam logic [1:0] D_DOWN  = 2'd2;
    localparam logic [1:0] D_LEFT  = 2'd3;

    localparam logic [1:0] M_CHASE   = 2'b00;
    localparam logic [1:0] M_SCATTER = 2'b01;

    localparam logic [CW-1:0] ZERO_C    = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] X_MAX     = CW'(MAP_W - 1);
    localparam logic [CW-1:0] Y_MAX     = CW'(MAP_H - 1);
    localparam logic [CW-1:0] START_XC  = CW'(START_X);
    localparam logic [CW-1:0] START_YC  = CW'(START_Y);
    localparam logic [CW-1:0] SCAT_XC   = CW'(SCAT_X);
    localparam logic [CW-1:0] SCAT_YC   = CW'(SCAT_Y);

    localparam logic signed [TW-1:0] ZERO_S  = {TW{1'b0}};
    localparam logic signed [TW-1:0] TWO_S   = TW'(2);
    localparam logic signed [TW-1:0] FOUR_S  = TW'(4);
    localparam logic signed [TW-1:0] X_MAX_S = TW'(MAP_W - 1);
    localparam logic signed [TW-1:0] Y_MAX_S = TW'(MAP_H - 1);

    localparam logic [DW-1:0] CLYDE_RADIUS = DW'(8);

    // Zero-extend a tile coordinate into the signed target domain.
    function automatic logic signed [TW-1:0] ext(input logic [CW-1:0] v);
        return $signed({3'b000, v});
    endfunction

    // Move a signed X coordinate n tiles along direction d.
    function automatic logic signed [TW-1:0] offset_x(input logic signed [TW-1:0] x,
                                                      input logic [1:0] d,
                                                      input logic signed [TW-1:0] n);
        case (d)
            D_RIGHT: return x + n;
            D_LEFT:  return x - n;
            default: return x;
        endcase
    endfunction

    // Move a signed Y coordinate n tiles along direction d (up is -Y).
    function automatic logic signed [TW-1:0] offset_y(input logic signed [TW-1:0] y,
                                                      input logic [1:0] d,
                                                      input logic signed [TW-1:0] n);
        case (d)
            D_UP:    return y - n;
            D_DOWN:  return y + n;
            default: return y;
        endcase
    endfunction

    // Clamp a signed coordinate into [0, vmax].
    function automatic logic [CW-1:0] clamp(input logic signed [TW-1:0] v,
                                            input logic signed [TW-1:0] vmax);
        if (v < ZERO_S) begin
            return ZERO_C;
        end else if (v > vmax) begin
            return vmax[CW-1:0];
        end else begin
            return v[CW-1:0];
        end
    endfunction

    // Absolute difference of two unsigned coordinates.
    function automatic logic [CW-1:0] abs_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
        if (a >= b) begin
            return a - b;
        end else begin
            return b - a;
        end
    endfunction

    // Manhattan distance between two tiles.
    function automatic logic [DW-1:0] manhattan(input logic [CW-1:0] ax, input logic [CW-1:0] ay,
                                                input logic [CW-1:0] bx, input logic [CW-1:0] by);
        return {2'b00, abs_diff(ax, bx)} + {2'b00, abs_diff(ay, by)};
    endfunction

    // Tie-break order for the greedy choice: up, left, down, right.
    function automatic logic [1:0] prio_dir(input logic [1:0] k);
        case (k)
            2'd0:    return D_UP;
            2'd1:    return D_LEFT;
            2'd2:    return D_DOWN;
            default: return D_RIGHT;
        endcase
    endfunction

    logic [1:0]    state_r;
    logic [CW-1:0] tgt_x_r;
    logic [CW-1:0] tgt_y_r;
    logic [1:0]    prev_mode_r;
    logic          rev_flag_r;
    logic          move_r;

    logic signed [TW-1:0] pac_x_s;
    logic signed [TW-1:0] pac_y_s;
    logic signed [TW-1:0] ahead_x_s;
    logic signed [TW-1:0] ahead_y_s;
    logic signed [TW-1:0] chase_x_s;
    logic signed [TW-1:0] chase_y_s;
    logic                 clyde_far_s;
    logic [CW-1:0]        tgt_x_s;
    logic [CW-1:0]        tgt_y_s;

    logic [CW-1:0] left_x_s;
    logic [CW-1:0] right_x_s;
    logic [CW-1:0] up_y_s;
    logic [CW-1:0] down_y_s;
    logic [DW-1:0] dist_s [4];

    logic [3:0]    open_s;
    logic [3:0]    cand_s;
    logic [1:0]    rev_s;
    logic [1:0]    best_dir_s;
    logic [DW-1:0] best_d_s;
    logic          found_s;
    logic [1:0]    idx_s;
    logic          take_s;
    logic [1:0]    pick_dir_s;
    logic [1:0]    next_dir_s;
    logic          move_s;

`ifdef GHOST_FRIGHT_EN
    localparam logic [1:0]  M_FRIGHT   = 2'b10;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1 + 16'(GHOST_ID);

    logic [15:0] lfsr_r;
    logic        fright_r;
    logic [1:0]  rand_dir_s;
    logic        rand_found_s;
    logic [1:0]  rand_idx_s;
    logic        rand_take_s;
`endif

    // Personality target for chase mode, and final target selection by mode.
    always_comb begin
        pac_x_s     = ext(pacX);
        pac_y_s     = ext(pacY);
        ahead_x_s   = offset_x(pac_x_s, pacDir, TWO_S);
        ahead_y_s   = offset_y(pac_y_s, pacDir, TWO_S);
        clyde_far_s = (manhattan(ghostX, ghostY, pacX, pacY) > CLYDE_RADIUS);
        chase_x_s   = pac_x_s;
        chase_y_s   = pac_y_s;
        if (GHOST_ID == 1) begin
            chase_x_s = offset_x(pac_x_s, pacDir, FOUR_S);
            chase_y_s = offset_y(pac_y_s, pacDir, FOUR_S);
        end else if (GHOST_ID == 2) begin
            chase_x_s = (ahead_x_s <<< 1) - ext(blinkyX);
            chase_y_s = (ahead_y_s <<< 1) - ext(blinkyY);
        end else if (GHOST_ID == 3) begin
            chase_x_s = clyde_far_s ? pac_x_s : ext(SCAT_XC);
            chase_y_s = clyde_far_s ? pac_y_s : ext(SCAT_YC);
        end else begin
            chase_x_s = pac_x_s;
            chase_y_s = pac_y_s;
        end
        if (mode == M_CHASE) begin
            tgt_x_s = clamp(chase_x_s, X_MAX_S);
            tgt_y_s = clamp(chase_y_s, Y_MAX_S);
        end else begin
            tgt_x_s = SCAT_XC;
            tgt_y_s = SCAT_YC;
        end
    end

    // Neighbour tiles (horizontal wrap) and their distances to the target.
    always_comb begin
        left_x_s  = (ghostX == ZERO_C) ? X_MAX : ghostX - ONE_C;
        right_x_s = (ghostX == X_MAX) ? ZERO_C : ghostX + ONE_C;
        up_y_s    = ghostY - ONE_C;
        down_y_s  = ghostY + ONE_C;
        dist_s[D_UP]    = manhattan(ghostX, up_y_s, tgt_x_r, tgt_y_r);
        dist_s[D_RIGHT] = manhattan(right_x_s, ghostY, tgt_x_r, tgt_y_r);
        dist_s[D_DOWN]  = manhattan(ghostX, down_y_s, tgt_x_r, tgt_y_r);
        dist_s[D_LEFT]  = manhattan(left_x_s, ghostY, tgt_x_r, tgt_y_r);
    end

    // Greedy minimum-distance pick among open, non-reverse neighbours.
    always_comb begin
        open_s     = {canMoveLeft, canMoveDown, canMoveRight, canMoveUp};
        rev_s      = dir ^ 2'b10;
        cand_s     = open_s & ~(4'b0001 << rev_s);
        best_dir_s = D_UP;
        best_d_s   = {DW{1'b1}};
        found_s    = 1'b0;
        idx_s      = D_UP;
        take_s     = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx_s      = prio_dir(k[1:0]);
            take_s     = cand_s[idx_s] && (!found_s || (dist_s[idx_s] < best_d_s));
            best_dir_s = take_s ? idx_s : best_dir_s;
            best_d_s   = take_s ? dist_s[idx_s] : best_d_s;
            found_s    = found_s | take_s;
        end
    end

`ifdef GHOST_FRIGHT_EN
    // Frightened pick: first legal direction rotating from lfsr[1:0].
    always_comb begin
        rand_dir_s   = lfsr_r[1:0];
        rand_found_s = 1'b0;
        rand_idx_s   = lfsr_r[1:0];
        rand_take_s  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rand_idx_s   = lfsr_r[1:0] + k[1:0];
            rand_take_s  = !rand_found_s && cand_s[rand_idx_s];
            rand_dir_s   = rand_take_s ? rand_idx_s : rand_dir_s;
            rand_found_s = rand_found_s | rand_take_s;
        end
        pick_dir_s = fright_r ? rand_dir_s : best_dir_s;
    end
`else
    // Without frightened support the greedy pick is always used.
    always_comb begin
        pick_dir_s = best_dir_s;
    end
`endif

    // Final direction: forced reversal, normal pick, sole reverse, or stay.
    always_comb begin
        next_dir_s = dir;
        move_s     = 1'b0;
        if (rev_flag_r && open_s[rev_s]) begin
            next_dir_s = rev_s;
            move_s     = 1'b1;
        end else if (cand_s != 4'b0000) begin
            next_dir_s = pick_dir_s;
            move_s     = 1'b1;
        end else if (open_s[rev_s]) begin
            next_dir_s = rev_s;
            move_s     = 1'b1;
        end else begin
            next_dir_s = dir;
            move_s     = 1'b0;
        end
    end

    // Step sequencer: one cycle per state, ticks accepted only in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            busy      <= 1'b0;
            step_done <= 1'b0;
        end else begin
            step_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (move_tick) begin
                        state_r <= TARGET;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                TARGET: state_r <= DECIDE;
                DECIDE: state_r <= STEP;
                STEP: begin
                    state_r   <= IDLE;
                    busy      <= 1'b0;
                    step_done <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Latch target and mode history in TARGET; reversal request is used once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tgt_x_r     <= START_XC;
            tgt_y_r     <= START_YC;
            prev_mode_r <= M_SCATTER;
            rev_flag_r  <= 1'b0;
        end else if (state_r == TARGET) begin
            tgt_x_r     <= tgt_x_s;
            tgt_y_r     <= tgt_y_s;
            prev_mode_r <= mode;
            rev_flag_r  <= rev_flag_r | (mode != prev_mode_r);
        end else if (state_r == DECIDE) begin
            rev_flag_r  <= 1'b0;
        end
    end

`ifdef GHOST_FRIGHT_EN
    // Frightened flag latched with the target; LFSR advances every DECIDE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fright_r <= 1'b0;
            lfsr_r   <= LFSR_SEED;
        end else if (state_r == TARGET) begin
            fright_r <= (mode == M_FRIGHT);
        end else if (state_r == DECIDE) begin
            lfsr_r   <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        end
    end
`endif

    // Register the chosen heading and whether the ghost will move.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir    <= D_RIGHT;
            move_r <= 1'b0;
        end else if (state_r == DECIDE) begin
            dir    <= next_dir_s;
            move_r <= move_s;
        end
    end

    // Apply the one-tile move in STEP; X wraps, Y saturates at the map edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghostX <= START_XC;
            ghostY <= START_YC;
        end else if ((state_r == STEP) && move_r) begin
            case (dir)
                D_UP:    ghostY <= (ghostY == ZERO_C) ? ghostY : up_y_s;
                D_RIGHT: ghostX <= right_x_s;
                D_DOWN:  ghostY <= (ghostY == Y_MAX) ? ghostY : down_y_s;
                D_LEFT:  ghostX <= left_x_s;
                default: ghostX <= ghostX;
            endcase
        end
    end

endmodule

// File: tb/tb_ghost_ai.sv
// Directed bench for ghost_ai (Inky, default map). Expected tiles are
// pushed to a scoreboard when a tick is issued and compared on step_done.
module tb_ghost_ai;

    logic       clk = 1'b0;
    logic       reset;
    logic       move_tick;
    logic [1:0] mode;
    logic [5:0] pacX, pacY, blinkyX, blinkyY;
    logic [1:0] pacDir;
    logic       canMoveUp, canMoveRight, canMoveDown, canMoveLeft;
    logic [5:0] ghostX, ghostY;
    logic [1:0] dir;
    logic       step_done, busy;

    typedef struct packed {
        logic [5:0] x;
        logic [5:0] y;
        logic [1:0] d;
    } exp_t;

    exp_t sb_q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   done_count = 0;

    always #5 clk = ~clk;

    ghost_ai #(.GHOST_ID(2)) dut (
        .clk(clk), .reset(reset), .move_tick(move_tick), .mode(mode),
        .pacX(pacX), .pacY(pacY), .pacDir(pacDir),
        .blinkyX(blinkyX), .blinkyY(blinkyY),
        .canMoveUp(canMoveUp), .canMoveRight(canMoveRight),
        .canMoveDown(canMoveDown), .canMoveLeft(canMoveLeft),
        .ghostX(ghostX), .ghostY(ghostY), .dir(dir),
        .step_done(step_done), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every step_done pops one expectation.
    always @(negedge clk) begin
        if (step_done === 1'b1) begin
            exp_t e;
            done_count++;
            chk("step_done_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_x", 32'(ghostX), 32'(e.x));
                chk("sb_y", 32'(ghostY), 32'(e.y));
                chk("sb_dir", 32'(dir), 32'(e.d));
            end
        end
    end

    task automatic set_open(input logic u, input logic r, input logic d, input logic l);
        canMoveUp = u; canMoveRight = r; canMoveDown = d; canMoveLeft = l;
    endtask

    task automatic push_exp(input int x, input int y, input int d);
        exp_t e;
        e.x = 6'(x); e.y = 6'(y); e.d = 2'(d);
        sb_q.push_back(e);
    endtask

    // Pulse move_tick; returns one cycle after the accepting edge.
    task automatic pulse_tick();
        @(posedge clk); #1 move_tick = 1'b1;
        @(posedge clk); #1 move_tick = 1'b0;
    endtask

    task automatic wait_done(input int n0, input string tag);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            if (done_count != n0) break;
        end
        chk(tag, 32'(done_count != n0), 32'd1);
    endtask

    task automatic do_step(input int x, input int y, input int d);
        int n0;
        n0 = done_count;
        push_exp(x, y, d);
        pulse_tick();
        wait_done(n0, "step_timeout");
    endtask

    initial begin
        int n0;
        reset = 1'b1; move_tick = 1'b0; mode = 2'b01;
        pacX = 6'd10; pacY = 6'd10; pacDir = 2'b01;
        blinkyX = 6'd8; blinkyY = 6'd8;
        set_open(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x", 32'(ghostX), 32'd11);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Idle with no ticks: nothing moves.
        repeat (10) @(posedge clk);
        #1;
        chk("idle_x", 32'(ghostX), 32'd11);
        chk("idle_y", 32'(ghostY), 32'd19);
        chk("idle_dir", 32'(dir), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(step_done), 32'd0);

        // A: chase after scatter at reset -> forced reversal to the left; latency.
        mode = 2'b00;
        push_exp(10, 19, 3);
        pulse_tick();
        chk("lat_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("lat_x_before", 32'(ghostX), 32'd11);
        chk("lat_done_early", 32'(step_done), 32'd0);
        @(posedge clk); #1;
        chk("lat_done", 32'(step_done), 32'd1);
        chk("lat_x_after", 32'(ghostX), 32'd10);
        @(posedge clk); #1;
        chk("lat_done_pulse", 32'(step_done), 32'd0);
        chk("lat_busy_end", 32'(busy), 32'd0);

        // B: only the reverse tile is open -> take it.
        set_open(1'b0, 1'b1, 1'b0, 1'b0);
        do_step(11, 19, 1);

        // C: Inky target (16,12); up closed, right beats down.
        set_open(1'b0, 1'b1, 1'b1, 1'b1);
        do_step(12, 19, 1);

        // D: chase -> scatter forces reversal; E: next step is greedy again.
        mode = 2'b01;
        set_open(1'b1, 1'b1, 1'b1, 1'b1);
        do_step(11, 19, 3);
        do_step(11, 20, 2);

        // F: second tick one cycle later is ignored.
        set_open(1'b0, 1'b0, 1'b0, 1'b1);
        n0 = done_count;
        push_exp(10, 20, 3);
        @(posedge clk); #1 move_tick = 1'b1;
        @(posedge clk); #1 move_tick = 1'b0;
        @(posedge clk); #1 move_tick = 1'b1;
        @(posedge clk); #1 move_tick = 1'b0;
        repeat (15) @(posedge clk);
        chk("double_tick_count", 32'(done_count - n0), 32'd1);

        // G: fully boxed in -> no move, dir kept, step_done still pulses.
        set_open(1'b0, 1'b0, 1'b0, 1'b0);
        do_step(10, 20, 3);

        // H/I: walk up to row 17 then left to column 0.
        set_open(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) do_step(10, 20 - i, 0);
        set_open(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 10; i++) do_step(10 - i, 17, 3);

        // J: left from X=0 wraps to 27; K: right from 27 wraps to 0.
        do_step(27, 17, 3);
        set_open(1'b0, 1'b1, 1'b0, 1'b0);
        do_step(0, 17, 1);

        // L/M: mode 10 without frightened support acts as scatter.
        mode = 2'b10;
        set_open(1'b1, 1'b1, 1'b1, 1'b1);
        do_step(27, 17, 3);
        do_step(27, 18, 2);

        // N: walls changed during STEP do not affect the step.
        set_open(1'b0, 1'b0, 1'b1, 1'b0);
        n0 = done_count;
        push_exp(27, 19, 2);
        pulse_tick();
        @(posedge clk); #1;
        @(posedge clk); #1;
        set_open(1'b0, 1'b0, 1'b0, 1'b1);
        wait_done(n0, "late_input_timeout");

        // O: reset during STEP abandons the step.
        set_open(1'b1, 1'b1, 1'b1, 1'b1);
        n0 = done_count;
        pulse_tick();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("rst_step_x", 32'(ghostX), 32'd11);
        chk("rst_step_y", 32'(ghostY), 32'd19);
        chk("rst_step_dir", 32'(dir), 32'd1);
        chk("rst_step_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (8) @(posedge clk);
        chk("rst_step_no_done", 32'(done_count - n0), 32'd0);
        chk("rst_step_x_after", 32'(ghostX), 32'd11);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
